// File: rtl/regbank_dump_pkg.sv
// Purpose: shared widths and FSM state encoding for the register bank dumper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regbank_dump_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int BYTE_W     = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } dumpState_t;

endpackage

// File: rtl/dump_byte_serializer.sv
// Purpose: turns one loaded register word (plus optional index) into a byte stream.
// Latency: first byte valid the cycle after load; one byte per accepted handshake.
// Backpressure: out_data/out_valid hold until out_valid && out_ready.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (drops any partial record)
//   load            one-cycle strobe: capture loadData/loadIndex and start a record
//   loadData        register word, sent MSB byte first
//   loadIndex       register index, sent first when SEND_INDEX != 0
//   out_data/out_valid/out_ready  byte stream handshake
//   lastAccept      pulses in the cycle the record's final byte is accepted
module dump_byte_serializer
  import regbank_dump_pkg::*;
#(
  parameter int SEND_INDEX = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_W-1:0]     loadData,
  input  logic [REG_ADDR_W-1:0] loadIndex,
  output logic [BYTE_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  lastAccept
);

  localparam logic [2:0] RECORD_LEN = (SEND_INDEX != 0) ? 3'd5 : 3'd4;

  logic [DATA_W-1:0]     shiftReg;
  logic [REG_ADDR_W-1:0] indexReg;
  logic [2:0]            byteCnt;
  logic                  validReg;
  logic                  accept;
  logic                  onIndex;

  assign accept     = validReg && out_ready;
  // The index byte is the first of a 5-byte record; the data word is not
  // shifted while it is on the wire.
  assign onIndex    = (SEND_INDEX != 0) && (byteCnt == 3'd5);
  assign lastAccept = accept && (byteCnt == 3'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      shiftReg <= '0;
      indexReg <= '0;
      byteCnt  <= '0;
      validReg <= 1'b0;
    end else if (load) begin
      shiftReg <= loadData;
      indexReg <= loadIndex;
      byteCnt  <= RECORD_LEN;
      validReg <= 1'b1;
    end else if (accept) begin
      if (!onIndex) begin
        shiftReg <= {shiftReg[DATA_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
      end
      byteCnt <= byteCnt - 3'd1;
      if (byteCnt == 3'd1) begin
        validReg <= 1'b0;
      end
    end
  end

  always_comb begin
    out_data = '0;
    if (validReg) begin
      out_data = onIndex ? {{(BYTE_W-REG_ADDR_W){1'b0}}, indexReg}
                         : shiftReg[DATA_W-1:DATA_W-BYTE_W];
    end
  end

  assign out_valid = validReg;

endmodule

// File: rtl/regbank_dumper.sv
// Purpose: walks a (possibly wrapping) register index range and streams each register out as bytes.
// Latency: first byte valid 2 cycles after start; each record costs 1 load cycle + 4/5 byte cycles.
// Backpressure: byte stream stalls on out_ready low; the FSM waits in SEND, nothing is dropped.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                dump request, only honoured in IDLE
//   first_reg, last_reg  inclusive index range, latched on start; last < first wraps through 31
//   abort                stop after the record currently in flight
//   rd_addr, rd_data     combinational register bank read port
//   out_data/out_valid/out_ready  byte stream
//   busy, done           activity flag and one-cycle completion pulse
module regbank_dumper
  import regbank_dump_pkg::*;
#(
  parameter int SEND_INDEX = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [REG_ADDR_W-1:0] first_reg,
  input  logic [REG_ADDR_W-1:0] last_reg,
  input  logic                  abort,
  output logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  output logic [BYTE_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  dumpState_t            state;
  dumpState_t            nextState;
  logic [REG_ADDR_W-1:0] cur;
  logic [REG_ADDR_W-1:0] endReg;
  logic                  abortLatched;
  logic                  loadStrobe;
  logic                  lastAccept;
  logic                  recordEnd;

  // An abort arriving in the very cycle of the last byte still counts.
  assign recordEnd = abort || abortLatched || (cur == endReg);

  dump_byte_serializer #(
    .SEND_INDEX(SEND_INDEX)
  ) u_serializer (
    .clk       (clk),
    .rst       (rst),
    .load      (loadStrobe),
    .loadData  (rd_data),
    .loadIndex (cur),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lastAccept(lastAccept)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = LOAD;
      LOAD:    nextState = SEND;
      SEND:    if (lastAccept) nextState = recordEnd ? FINISH : LOAD;
      FINISH:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy       = (state != IDLE);
    done       = (state == FINISH);
    loadStrobe = (state == LOAD);
    rd_addr    = (state == IDLE) ? '0 : cur;
  end

  // Range and abort bookkeeping; cur wraps naturally at the address width.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur          <= '0;
      endReg       <= '0;
      abortLatched <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          abortLatched <= 1'b0;
          if (start) begin
            cur    <= first_reg;
            endReg <= last_reg;
          end
        end
        LOAD: begin
          if (abort) abortLatched <= 1'b1;
        end
        SEND: begin
          if (abort) abortLatched <= 1'b1;
          if (lastAccept && !recordEnd) cur <= cur + REG_ADDR_W'(1);
        end
        default: begin
          abortLatched <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_dumper.sv
module tb_regbank_dumper;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start2;
  logic [4:0]  firstReg, lastReg;
  logic        abort1;
  logic [4:0]  rdAddr1, rdAddr2;
  logic [31:0] rdData1, rdData2;
  logic [7:0]  outData1, outData2;
  logic        outValid1, outValid2;
  logic        outReady1, outReady2;
  logic        busy1, busy2, done1, done2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // out_ready pattern 1,0,0,1 for the stall scenario
  logic [3:0] pat = 4'b1001;
  logic [1:0] phase = 2'd0;
  logic       toggleEn = 1'b0;

  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] expQ[$];
  int doneCnt1 = 0, doneCnt2 = 0;
  int doneCyc1 = 0, lastAccCyc1 = 0;
  int startCyc = 0;
  logic       prevStall1 = 1'b0;
  logic [7:0] prevData1 = 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    phase <= phase + 2'd1;
  end

  assign outReady1 = toggleEn ? pat[phase] : 1'b1;
  assign outReady2 = 1'b1;
  assign rdData1   = 32'hA000_0000 + {27'd0, rdAddr1};
  assign rdData2   = (rdAddr2 == 5'd7) ? 32'hDEAD_BEEF : 32'h5555_5555;

  regbank_dumper #(.SEND_INDEX(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .first_reg(firstReg), .last_reg(lastReg),
    .abort(abort1), .rd_addr(rdAddr1), .rd_data(rdData1), .out_data(outData1),
    .out_valid(outValid1), .out_ready(outReady1), .busy(busy1), .done(done1)
  );

  regbank_dumper #(.SEND_INDEX(0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .first_reg(firstReg), .last_reg(lastReg),
    .abort(1'b0), .rd_addr(rdAddr2), .rd_data(rdData2), .out_data(outData2),
    .out_valid(outValid2), .out_ready(outReady2), .busy(busy2), .done(done2)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Byte capture, done tracking and stall-stability check, sampled mid-cycle.
  always @(negedge clk) begin
    if (done1) begin doneCnt1++; doneCyc1 = cyc; end
    if (done2) doneCnt2++;
    if (!rst && outValid1 && outReady1) begin q1.push_back(outData1); lastAccCyc1 = cyc; end
    if (!rst && outValid2 && outReady2) q2.push_back(outData2);
    if (prevStall1 && outValid1 && !rst) check("stall_stable", {24'd0, outData1}, {24'd0, prevData1});
    prevStall1 = outValid1 && !outReady1 && !rst;
    prevData1  = outData1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void pushRecord(input int idx, input bit withIndex, input logic [31:0] v);
    if (withIndex) expQ.push_back(8'(idx));
    expQ.push_back(v[31:24]);
    expQ.push_back(v[23:16]);
    expQ.push_back(v[15:8]);
    expQ.push_back(v[7:0]);
  endfunction

  task automatic startDump(input int sel, input logic [4:0] f, input logic [4:0] l);
    q1.delete(); q2.delete();
    doneCnt1 = 0; doneCnt2 = 0;
    firstReg = f; lastReg = l;
    if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
    startCyc = cyc;
    step();
    start1 = 1'b0; start2 = 1'b0;
  endtask

  task automatic waitDone(input int sel, input string name);
    for (int i = 0; i < 3000 && ((sel == 1) ? doneCnt1 : doneCnt2) == 0; i++) step();
    step(); step(); step();
    check({name, "_done_once"}, (sel == 1) ? doneCnt1 : doneCnt2, 1);
    check({name, "_idle"}, {31'd0, (sel == 1) ? busy1 : busy2}, 0);
  endtask

  task automatic checkBytes(input int sel, input string name);
    int n;
    n = (sel == 1) ? q1.size() : q2.size();
    check({name, "_count"}, n, expQ.size());
    for (int i = 0; i < expQ.size() && i < n; i++)
      check($sformatf("%s_byte%0d", name, i), {24'd0, (sel == 1) ? q1[i] : q2[i]}, {24'd0, expQ[i]});
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; abort1 = 1'b0;
    firstReg = 5'd0; lastReg = 5'd0;
    step(); step(); step();
    check("rst_valid", {31'd0, outValid1}, 0);
    check("rst_data", {24'd0, outData1}, 0);
    check("rst_busy", {31'd0, busy1}, 0);
    check("rst_done", {31'd0, done1}, 0);
    check("rst_addr", {27'd0, rdAddr1}, 0);
    check("rst_valid2", {31'd0, outValid2}, 0);
    rst = 1'b0;
    step();

    // Scenario 1: regs 2..3 with index bytes, ready always high
    expQ = '{8'h02, 8'hA0, 8'h00, 8'h00, 8'h02, 8'h03, 8'hA0, 8'h00, 8'h00, 8'h03};
    startDump(1, 5'd2, 5'd3);
    check("s1_load_valid", {31'd0, outValid1}, 0);
    check("s1_load_addr", {27'd0, rdAddr1}, 2);
    check("s1_load_busy", {31'd0, busy1}, 1);
    step();
    check("s1_first_valid", {31'd0, outValid1}, 1);
    check("s1_first_data", {24'd0, outData1}, 32'h02);
    waitDone(1, "s1");
    checkBytes(1, "s1");
    check("s1_last_byte_cyc", lastAccCyc1 - startCyc, 12);
    check("s1_done_cyc", doneCyc1 - startCyc, 13);
    check("s1_idle_addr", {27'd0, rdAddr1}, 0);

    // Scenario 2: wrap 30..1; a stray start mid-dump is ignored
    expQ.delete();
    pushRecord(30, 1, 32'hA000_001E);
    pushRecord(31, 1, 32'hA000_001F);
    pushRecord(0, 1, 32'hA000_0000);
    pushRecord(1, 1, 32'hA000_0001);
    startDump(1, 5'd30, 5'd1);
    step(); step();
    firstReg = 5'd10; lastReg = 5'd12; start1 = 1'b1;
    step();
    start1 = 1'b0;
    waitDone(1, "s2");
    checkBytes(1, "s2");

    // Scenario 3: stalled sink, same bytes as scenario 1
    expQ = '{8'h02, 8'hA0, 8'h00, 8'h00, 8'h02, 8'h03, 8'hA0, 8'h00, 8'h00, 8'h03};
    toggleEn = 1'b1;
    startDump(1, 5'd2, 5'd3);
    waitDone(1, "s3");
    toggleEn = 1'b0;
    checkBytes(1, "s3");

    // Scenario 4: full range, abort during the second byte of register 5's record
    expQ.delete();
    for (int r = 0; r <= 5; r++) pushRecord(r, 1, 32'hA000_0000 + r);
    startDump(1, 5'd0, 5'd31);
    for (int i = 0; i < 3000 && q1.size() != 26; i++) step();
    check("s4_abort_point", {24'd0, outData1}, 32'hA0);
    abort1 = 1'b1;
    step();
    abort1 = 1'b0;
    waitDone(1, "s4");
    checkBytes(1, "s4");

    // Scenario 5: reset on the third byte of the second record, then a clean rerun
    startDump(1, 5'd2, 5'd3);
    for (int i = 0; i < 3000 && q1.size() != 7; i++) step();
    check("s5_pre_rst_data", {24'd0, outData1}, 32'h00);
    rst = 1'b1;
    step();
    check("s5_rst_valid", {31'd0, outValid1}, 0);
    check("s5_rst_busy", {31'd0, busy1}, 0);
    check("s5_rst_done", {31'd0, done1}, 0);
    check("s5_rst_addr", {27'd0, rdAddr1}, 0);
    rst = 1'b0;
    step(); step();
    check("s5_no_done", doneCnt1, 0);
    expQ = '{8'h02, 8'hA0, 8'h00, 8'h00, 8'h02, 8'h03, 8'hA0, 8'h00, 8'h00, 8'h03};
    startDump(1, 5'd2, 5'd3);
    waitDone(1, "s5");
    checkBytes(1, "s5");

    // Scenario 6: no index bytes, single register 7
    expQ = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    startDump(2, 5'd7, 5'd7);
    step();
    check("s6_first_data", {24'd0, outData2}, 32'hDE);
    waitDone(2, "s6");
    checkBytes(2, "s6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regbank_dumper.md
REGBANK_DUMPER -- requirements
Module: regbank_dumper

Interface
REQ-001 Parameter SEND_INDEX, default 1: when 1, each register record is prefixed by its index byte; when 0, the record is data bytes only.
REQ-002 clk  input  1  Clock; all state changes on the rising edge.
REQ-003 rst  input  1  Reset, synchronous, active-high.
REQ-004 start  input  1  Request a dump; sampled only in IDLE.
REQ-005 first_reg  input  5  First register index of the dump range; latched on start.
REQ-006 last_reg  input  5  Last register index of the dump range (inclusive); latched on start.
REQ-007 abort  input  1  Terminate the dump at the next record boundary.
REQ-008 rd_addr  output  5  Read address to the register bank read port.
REQ-009 rd_data  input  32  Combinational read data from the register bank for rd_addr.
REQ-010 out_data  output  8  Byte stream data.
REQ-011 out_valid  output  1  out_data is valid.
REQ-012 out_ready  input  1  Sink accepts the byte when out_valid and out_ready are both high.
REQ-013 busy  output  1  High in every state except IDLE.
REQ-014 done  output  1  One-cycle pulse marking completion or abort.

Function
REQ-015 The FSM states shall be IDLE, LOAD, SEND and FINISH.
REQ-016 In IDLE, start=1 shall latch first_reg into cur and last_reg into end, then enter LOAD.
REQ-017 In LOAD (one cycle), rd_addr shall equal cur and rd_data shall be captured into a 32-bit shift register; the byte counter shall be set to 4, or to 5 when SEND_INDEX=1; the next state is SEND.
REQ-018 Byte order in SEND: index byte {3'b000,cur} first when SEND_INDEX=1, then rd_data[31:24], [23:16], [15:8], [7:0].
REQ-019 out_valid shall be high throughout SEND; out_data shall stay stable until accepted; a byte advances only on out_valid&&out_ready.
REQ-020 On acceptance of a record's last byte: if abort=1 or cur==end, go to FINISH; otherwise set cur=cur+1 (mod 32, so 31 wraps to 0) and go to LOAD.
REQ-021 Wrap-around: when last_reg<first_reg, the dump shall cover first_reg..31 and then 0..last_reg; when first_reg==last_reg, exactly one record is sent.
REQ-022 abort asserted at any time in LOAD or SEND shall be latched; the current record completes and no further record starts.
REQ-023 FINISH lasts one cycle, asserts done=1, then returns to IDLE; start is ignored outside IDLE.
REQ-024 The first byte's out_valid shall rise 2 cycles after the start cycle.
REQ-025 With out_ready held high, each record takes 1+N cycles, where N is 4 or 5 bytes.
REQ-026 rd_addr shall equal cur in all states and 0 in IDLE.

Reset
REQ-027 rst=1 shall force IDLE from any state, including mid-record, and drop the partial record.
REQ-028 Reset values: out_valid=0, out_data=0, busy=0, done=0, rd_addr=0, cur=0, end=0, shift register=0, latched abort=0.
REQ-029 rst shall take priority over start and abort in the same cycle.

Structure
REQ-030 Package regbank_dump_pkg shall hold the state enum, REG_ADDR_W=5, DATA_W=32 and BYTE_W=8.
REQ-031 A single sub-module, dump_byte_serializer, shall hold the load/shift register, the byte counter and the valid/ready handshake; the FSM and address sequencing stay in regbank_dumper.

Verification
REQ-032 Scenario 1: bank holds reg[i]=32'hA0000000+i; first=2, last=3, SEND_INDEX=1, out_ready=1 -> bytes 02 A0 00 00 02 03 A0 00 00 03, then done one cycle after the last byte.
REQ-033 Scenario 2: first=30, last=1 -> records sent for registers 30, 31, 0, 1 in order, then done.
REQ-034 Scenario 3: out_ready toggled 1,0,0,1 per cycle -> out_data stable while stalled, no byte duplicated or lost, byte sequence identical to Scenario 1.
REQ-035 Scenario 4: first=0, last=31, abort pulsed during the second byte of record 5 -> record 5 completes, record 6 never starts, done pulses once.
REQ-036 Scenario 5: rst asserted during record 2's third byte -> next cycle out_valid=0, busy=0, done=0; a new start then behaves as in Scenario 1.
REQ-037 Scenario 6: SEND_INDEX=0, first=last=7, reg7=32'hDEADBEEF -> exactly DE AD BE EF, then done.
